yankee_feeder: RTL and testbench

Upstream operand sequencer for the quadratic solver (y = a*x^2 + b*x + c, 16-bit truncated result).
- Buffers operand tuples pushed by the producer in a small FIFO.
- Issues one tuple at a time to the solver: one-cycle enable pulse, then waits for the solver's valid and ready.
- Returns each result with a one-cycle strobe, a running result count and a timeout error strobe.

---
 rtl/yankee_feeder.sv | 153 +++++++++++++++
 tb/tb_yankee_feeder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yankee_feeder.sv
// yankee_feeder: operand FIFO plus a sequencer that hands one {x,a,b,c}
// tuple at a time to the quadratic solver and returns its result, with a
// timeout abort when the solver never answers.
module yankee_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_push,
  input  logic [7:0]  in_x,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_c,
  output logic        in_full,
  output logic        in_overflow,
  output logic        slv_enable,
  output logic [7:0]  slv_x,
  output logic [15:0] slv_a,
  output logic [15:0] slv_b,
  output logic [15:0] slv_c,
  input  logic [15:0] slv_y,
  input  logic        slv_valid,
  input  logic        slv_ready,
  output logic [15:0] res_y,
  output logic        res_valid,
  output logic        res_err,
  output logic [15:0] res_count,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [7:0]  x;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } tuple_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_VALID, WAIT_READY} state_t;

  tuple_t        mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  state_t        state, state_nx;
  logic [15:0]   tmo_cnt;
  logic [16:0]   tmo_inc;
  logic          valid_q, rise, push_ok, pop, take, expire, nonempty;

  // Full comes from the registered count: a pop in the same cycle does not
  // make room for a push until the next cycle.
  assign in_full    = (count == CW'(DEPTH));
  assign nonempty   = (count != '0);
  assign push_ok    = in_push & ~in_full;
  // A valid that was already high last cycle is stale, only an edge counts.
  assign rise       = slv_valid & ~valid_q;
  assign tmo_inc    = {1'b0, tmo_cnt} + 17'd1;
  assign slv_enable = (state == ISSUE);
  assign busy       = (state != IDLE) | nonempty;

  // FIFO storage write; contents need no reset since pointers gate reads
  always_ff @(posedge clock) begin
    if (push_ok) mem[tail] <= tuple_t'({in_x, in_a, in_b, in_c});
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      in_overflow <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + AW'(1);
      if (pop)     head <= head + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (in_push & in_full) in_overflow <= 1'b1;
    end
  end

  // Sequencer state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Sequencer next state; a rise in the expiry cycle beats the timeout
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    take     = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (nonempty && slv_ready) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT_VALID;
      WAIT_VALID: begin
        if (rise) begin
          take     = 1'b1;
          state_nx = WAIT_READY;
        end else if (tmo_inc == 17'(TIMEOUT)) begin
          expire   = 1'b1;
          state_nx = WAIT_READY;
        end
      end
      WAIT_READY: if (slv_ready) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Operand registers, result capture, strobes and timeout counter
  always_ff @(posedge clock) begin
    if (reset) begin
      slv_x     <= '0;
      slv_a     <= '0;
      slv_b     <= '0;
      slv_c     <= '0;
      res_y     <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_count <= '0;
      tmo_cnt   <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q   <= slv_valid;
      res_valid <= take;
      res_err   <= expire;
      if (pop) begin
        slv_x <= mem[head].x;
        slv_a <= mem[head].a;
        slv_b <= mem[head].b;
        slv_c <= mem[head].c;
      end
      if (take) begin
        res_y     <= slv_y;
        res_count <= res_count + 16'd1;
      end
      if (state == ISSUE)           tmo_cnt <= '0;
      else if (state == WAIT_VALID) tmo_cnt <= tmo_inc[15:0];
    end
  end

endmodule

// File: tb/tb_yankee_feeder.sv
// Bench for yankee_feeder: solver model with configurable latency, a queue
// based reference of FIFO contents and expected result/err events.
module tb_yankee_feeder;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_push = 1'b0;
  logic [7:0]  in_x = '0;
  logic [15:0] in_a = '0, in_b = '0, in_c = '0;
  logic        in_full, in_overflow, slv_enable;
  logic [7:0]  slv_x;
  logic [15:0] slv_a, slv_b, slv_c;
  logic [15:0] slv_y = '0;
  logic        slv_valid = 1'b0;
  logic        slv_ready;
  logic        ready_block = 1'b0;
  logic [15:0] res_y, res_count;
  logic        res_valid, res_err, busy;

  assign slv_ready = ~ready_block;

  always #5 clock = ~clock;

  yankee_feeder #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .in_push(in_push),
    .in_x(in_x), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_full(in_full), .in_overflow(in_overflow), .slv_enable(slv_enable),
    .slv_x(slv_x), .slv_a(slv_a), .slv_b(slv_b), .slv_c(slv_c),
    .slv_y(slv_y), .slv_valid(slv_valid), .slv_ready(slv_ready),
    .res_y(res_y), .res_valid(res_valid), .res_err(res_err),
    .res_count(res_count), .busy(busy)
  );

  int compared = 0, mismatched = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] quad(input logic [7:0] x, input logic [15:0] a,
                                       input logic [15:0] b, input logic [15:0] c);
    int xs, r;
    xs = int'($signed(x));
    r  = int'($signed(a)) * xs * xs + int'($signed(b)) * xs + int'($signed(c));
    return r[15:0];
  endfunction

  // Solver model: latency per op from lat_q, else random or lat_def.
  // Latency 0 means the solver never answers. In hold mode valid stays high
  // between ops and drops one cycle before the fresh result edge.
  int          lat_q[$];
  int          lat_def = 5;
  int          cur_lat = 0;
  int          lat_left = -1;
  bit          hold_mode = 0, rnd_lat = 0;
  logic [15:0] pend_y;

  always @(posedge clock) begin
    #1;
    if (reset) begin
      lat_left  = -1;
      slv_valid = 1'b0;
      lat_q.delete();
    end else if (slv_enable) begin
      if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
      else if (rnd_lat)     cur_lat = int'($urandom_range(1, TMO + 2));
      else                  cur_lat = lat_def;
      pend_y   = quad(slv_x, slv_a, slv_b, slv_c);
      lat_left = (cur_lat == 0) ? -1 : cur_lat;
      if (!hold_mode) slv_valid = 1'b0;
    end else if (lat_left > 0) begin
      lat_left--;
      if (lat_left == 1 && hold_mode) slv_valid = 1'b0;
      if (lat_left == 0) begin
        slv_valid = 1'b1;
        slv_y     = pend_y;
      end
    end else if (lat_left == 0) begin
      if (!hold_mode) slv_valid = 1'b0;
      lat_left = -1;
    end
  end

  // Reference: queued tuples and the single expected completion event.
  typedef struct { logic [7:0] x; logic [15:0] a, b, c; } tup_t;
  typedef struct { int cyc; bit err; logic [15:0] y; } ev_t;
  tup_t        q[$];
  ev_t         evq[$];
  tup_t        tt;
  ev_t         ee;
  int          cyc = 0;
  bit          chk_zero = 0, prev_en = 0, m_ovf = 0, dv, de;
  logic [15:0] m_cnt = '0, m_y = '0;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      q.delete();
      evq.delete();
      m_ovf = 0; m_cnt = '0; m_y = '0; prev_en = 0; chk_zero = 1;
    end else begin
      if (chk_zero) begin
        chk("reset_state", 128'({in_full, in_overflow, slv_enable, slv_x, slv_a, slv_b, slv_c,
                                 res_y, res_valid, res_err, res_count, busy}), 128'(0));
        chk_zero = 0;
      end
      if (slv_enable) begin
        chk("en_one_cycle", 128'(prev_en), 128'(0));
        chk("issue_from_fifo", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) begin
          tt = q.pop_front();
          chk("operands", 128'({slv_x, slv_a, slv_b, slv_c}), 128'({tt.x, tt.a, tt.b, tt.c}));
          ee.err = (cur_lat == 0) || (cur_lat > TMO);
          ee.cyc = cyc + (ee.err ? TMO : cur_lat) + 1;
          ee.y   = quad(tt.x, tt.a, tt.b, tt.c);
          evq.push_back(ee);
        end
      end
      prev_en = slv_enable;
      dv = 0; de = 0;
      if (evq.size() > 0 && evq[0].cyc <= cyc) begin
        dv = !evq[0].err;
        de = evq[0].err;
        if (dv) begin m_y = evq[0].y; m_cnt++; end
        evq.delete(0);
      end
      chk("res_valid", 128'(res_valid), 128'(dv));
      chk("res_err", 128'(res_err), 128'(de));
      chk("res_y", 128'(res_y), 128'(m_y));
      chk("res_count", 128'(res_count), 128'(m_cnt));
      chk("in_full", 128'(in_full), 128'(q.size() == DEPTH));
      chk("in_overflow", 128'(in_overflow), 128'(m_ovf));
      if (in_push) begin
        if (q.size() < DEPTH) begin
          tt.x = in_x; tt.a = in_a; tt.b = in_b; tt.c = in_c;
          q.push_back(tt);
        end else m_ovf = 1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [7:0] x, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c);
    step();
    in_push = 1'b1; in_x = x; in_a = a; in_b = b; in_c = c;
  endtask

  task automatic push_one(input logic [7:0] x, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c);
    push(x, a, b, c);
    step();
    in_push = 1'b0;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    @(negedge clock);
    while ((busy || q.size() != 0 || evq.size() != 0) && n < maxc) begin
      @(negedge clock);
      n++;
    end
    chk("drain_idle", 128'({busy, q.size() != 0, evq.size() != 0}), 128'(0));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    reset = 1'b0;

    // single op, 5-cycle solver
    push_one(8'd2, 16'd1, 16'd3, 16'd4);
    drain(100);
    chk("t1_y", 128'(res_y), 128'(16'd14));
    chk("t1_cnt", 128'(res_count), 128'(16'd1));

    // negative operands and the x=-128 corner
    push_one(8'hFD, 16'd2, 16'hFFFB, 16'd7);
    drain(100);
    chk("t2_y", 128'(res_y), 128'(16'd40));
    push_one(8'h80, 16'd1, 16'd0, 16'd0);
    drain(100);
    chk("t2_y128", 128'(res_y), 128'(16'h4000));

    // burst of 5 with solver not ready: 4 stored, 5th dropped
    do_reset();
    ready_block = 1'b1;
    for (int i = 0; i < 5; i++)
      push(8'(i + 1), 16'(i), 16'(2 * i + 1), 16'(100 + i));
    step();
    in_push = 1'b0;
    chk("t3_full", 128'(in_full), 128'(1));
    chk("t3_ovf", 128'(in_overflow), 128'(1));
    ready_block = 1'b0;
    drain(200);
    chk("t3_cnt", 128'(res_count), 128'(16'd4));

    // stale valid held high between ops
    hold_mode = 1; lat_def = 3;
    push_one(8'd1, 16'd1, 16'd1, 16'd1);
    drain(100);
    push_one(8'd2, 16'd1, 16'd1, 16'd1);
    drain(100);
    chk("t4_y", 128'(res_y), 128'(16'd7));
    hold_mode = 0; lat_def = 5;

    // timeout then a normal op; boundary latency TMO then TMO+1
    lat_q.push_back(0);
    lat_q.push_back(4);
    push(8'd5, 16'd1, 16'd1, 16'd1);
    push(8'd3, 16'd1, 16'd0, 16'd0);
    step();
    in_push = 1'b0;
    drain(200);
    chk("t5_y", 128'(res_y), 128'(16'd9));
    chk("t5_cnt", 128'(res_count), 128'(16'd7));
    lat_q.push_back(TMO);
    lat_q.push_back(TMO + 1);
    push(8'd4, 16'd0, 16'd1, 16'd0);
    push(8'd6, 16'd0, 16'd1, 16'd0);
    step();
    in_push = 1'b0;
    drain(200);
    chk("t5_edge_y", 128'(res_y), 128'(16'd4));

    // reset mid-op with two entries still queued
    lat_q.push_back(0);
    for (int i = 0; i < 3; i++) push(8'(10 + i), 16'd1, 16'd2, 16'd3);
    step();
    in_push = 1'b0;
    step();
    step();
    chk("t6_busy_pre", 128'(busy), 128'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (30) step();
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_cnt", 128'(res_count), 128'(16'd0));

    // randomized traffic
    rnd_lat = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      in_push     = ($urandom_range(0, 2) == 0);
      in_x        = 8'($urandom);
      in_a        = 16'($urandom);
      in_b        = 16'($urandom);
      in_c        = 16'($urandom);
      ready_block = ($urandom_range(0, 7) == 0);
    end
    step();
    in_push = 1'b0;
    ready_block = 1'b0;
    drain(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
